// File: rtl/matrix_pkg.sv
// Shared geometry, width helpers and FSM state type for the matrix-multiply datapath.
package matrix_pkg;

    localparam int unsigned MATRIX_A_ROWS_DEF      = 8;
    localparam int unsigned MATRIX_B_ROWS_DEF      = 8;
    localparam int unsigned MATRIX_B_COLUMNS_DEF   = 8;
    localparam int unsigned MATRIX_C_MEM_DEPTH_DEF = 64;
    localparam int unsigned MATRIX_MEM_WIDTH_DEF   = 32;

    // Counter width that never collapses to zero bits (K=1 still needs a k register).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned TOTAL_RESULTS = MATRIX_A_ROWS_DEF * MATRIX_B_COLUMNS_DEF;
    localparam int unsigned TERM_CNT_W    = cnt_width(MATRIX_B_ROWS_DEF);
    localparam int unsigned RESULT_IDX_W  = cnt_width(TOTAL_RESULTS);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/mult_pipe.sv
// Two-stage multiplier: registered operands, then registered low-W product.
// Valid, last-term tag and result index ride alongside the data.
module mult_pipe #(
    parameter int unsigned W     = 32,
    parameter int unsigned IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic [W-1:0]     a_i,
    input  logic [W-1:0]     b_i,
    input  logic             last_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic             valid_o,
    output logic [W-1:0]     prod_o,
    output logic             last_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             pipe_busy_o
);

    logic             v1_q, v2_q;
    logic [W-1:0]     a_q, b_q, prod_q;
    logic             last1_q, last2_q;
    logic [IDX_W-1:0] idx1_q, idx2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            last1_q <= 1'b0;
            idx1_q  <= '0;
        end else begin
            v1_q <= valid_i;
            if (valid_i) begin
                a_q     <= a_i;
                b_q     <= b_i;
                last1_q <= last_i;
                idx1_q  <= idx_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q    <= 1'b0;
            prod_q  <= '0;
            last2_q <= 1'b0;
            idx2_q  <= '0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                // W-bit context keeps only the low W bits: wrap-around is intended.
                prod_q  <= a_q * b_q;
                last2_q <= last1_q;
                idx2_q  <= idx1_q;
            end
        end
    end

    assign valid_o     = v2_q;
    assign prod_o      = prod_q;
    assign last_o      = last2_q;
    assign idx_o       = idx2_q;
    assign pipe_busy_o = v1_q | v2_q;

endmodule

// File: rtl/dot_product_accumulator.sv
// Multiplies streamed (A, B) pairs, accumulates K products per result and writes
// each dot product to C memory in row-major order, then pulses done.
module dot_product_accumulator
    import matrix_pkg::*;
#(
    parameter int unsigned MATRIX_A_ROWS      = MATRIX_A_ROWS_DEF,
    parameter int unsigned MATRIX_B_ROWS      = MATRIX_B_ROWS_DEF,
    parameter int unsigned MATRIX_B_COLUMNS   = MATRIX_B_COLUMNS_DEF,
    parameter int unsigned MATRIX_C_MEM_DEPTH = MATRIX_C_MEM_DEPTH_DEF,
    parameter int unsigned MATRIX_MEM_WIDTH   = MATRIX_MEM_WIDTH_DEF
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start_i,
    input  logic                                  in_valid_i,
    output logic                                  in_ready_o,
    input  logic [MATRIX_MEM_WIDTH-1:0]           in_a_i,
    input  logic [MATRIX_MEM_WIDTH-1:0]           in_b_i,
    output logic                                  wr_en_o,
    output logic [$clog2(MATRIX_C_MEM_DEPTH)-1:0] wr_address_o,
    output logic [MATRIX_MEM_WIDTH-1:0]           wr_data_o,
    output logic                                  busy_o,
    output logic                                  done_o
);

    localparam int unsigned W     = MATRIX_MEM_WIDTH;
    localparam int unsigned TOTAL = MATRIX_A_ROWS * MATRIX_B_COLUMNS;
    localparam int unsigned KW    = cnt_width(MATRIX_B_ROWS);
    localparam int unsigned RW    = cnt_width(TOTAL);
    localparam int unsigned AW    = $clog2(MATRIX_C_MEM_DEPTH);

    localparam logic [KW-1:0] K_LAST = KW'(MATRIX_B_ROWS - 1);
    localparam logic [RW-1:0] R_LAST = RW'(TOTAL - 1);

    state_t         state_q, state_d;
    logic [KW-1:0]  k_q, k_d;
    logic [RW-1:0]  r_q, r_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   wr_data_q, wr_data_d;
    logic [AW-1:0]  wr_addr_q, wr_addr_d;
    logic           wr_en_q, wr_en_d;
    logic           clear_acc;

    logic           accept, term_last, pair_last;
    logic           p_valid, p_last, pipe_busy;
    logic [W-1:0]   p_prod;
    logic [RW-1:0]  p_idx;

    assign in_ready_o = (state_q == RUN);
    assign accept     = in_valid_i & in_ready_o;
    assign term_last  = (k_q == K_LAST);
    assign pair_last  = term_last & (r_q == R_LAST);

    mult_pipe #(
        .W     (W),
        .IDX_W (RW)
    ) u_mult_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_i     (accept),
        .a_i         (in_a_i),
        .b_i         (in_b_i),
        .last_i      (term_last),
        .idx_i       (r_q),
        .valid_o     (p_valid),
        .prod_o      (p_prod),
        .last_o      (p_last),
        .idx_o       (p_idx),
        .pipe_busy_o (pipe_busy)
    );

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        r_d       = r_q;
        clear_acc = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d   = RUN;
                    k_d       = '0;
                    r_d       = '0;
                    clear_acc = 1'b1;
                end
            end
            RUN: begin
                if (accept) begin
                    if (term_last) begin
                        k_d = '0;
                        r_d = r_q + 1'b1;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                    if (pair_last) state_d = DRAIN;
                end
            end
            // Empty pipe with a write strobe in flight means the final result just went out.
            DRAIN:   if (!pipe_busy && wr_en_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_d     = acc_q;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        wr_addr_d = wr_addr_q;
        if (clear_acc) begin
            acc_d = '0;
        end else if (p_valid) begin
            if (p_last) begin
                wr_data_d = acc_q + p_prod;
                wr_en_d   = 1'b1;
                wr_addr_d = AW'(p_idx);
                acc_d     = '0;
            end else begin
                acc_d = acc_q + p_prod;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            k_q       <= '0;
            r_q       <= '0;
            acc_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            wr_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            r_q       <= r_d;
            acc_q     <= acc_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            wr_addr_q <= wr_addr_d;
        end
    end

    assign wr_en_o      = wr_en_q;
    assign wr_data_o    = wr_data_q;
    assign wr_address_o = wr_addr_q;
    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == DONE);

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Directed bench for dot_product_accumulator: 8x8x8 passes with hand-derived results.
module tb_dot_product_accumulator;

    localparam int unsigned W    = 32;
    localparam int unsigned AW   = 6;
    localparam int unsigned NRES = 64;
    localparam int unsigned K    = 8;

    logic          clk;
    logic          rst_n;
    logic          start_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [W-1:0]  in_a_i;
    logic [W-1:0]  in_b_i;
    logic          wr_en_o;
    logic [AW-1:0] wr_address_o;
    logic [W-1:0]  wr_data_o;
    logic          busy_o;
    logic          done_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    dot_product_accumulator #(
        .MATRIX_A_ROWS      (8),
        .MATRIX_B_ROWS      (8),
        .MATRIX_B_COLUMNS   (8),
        .MATRIX_C_MEM_DEPTH (64),
        .MATRIX_MEM_WIDTH   (32)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_a_i       (in_a_i),
        .in_b_i       (in_b_i),
        .wr_en_o      (wr_en_o),
        .wr_address_o (wr_address_o),
        .wr_data_o    (wr_data_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Mode 0: A=I, B[k][j]=k*8+j. Mode 1: all ones. Mode 2: 0x10000 squared. Mode 3: -1 * 1.
    function automatic logic [31:0] pair_a(input int mode, input int r, input int k);
        case (mode)
            0:       return ((r / 8) == k) ? 32'd1 : 32'd0;
            1:       return 32'd1;
            2:       return 32'h0001_0000;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [31:0] pair_b(input int mode, input int r, input int k);
        case (mode)
            0:       return 32'(k * 8 + (r % 8));
            1:       return 32'd1;
            2:       return 32'h0001_0000;
            default: return 32'd1;
        endcase
    endfunction

    function automatic logic [31:0] exp_c(input int mode, input int r);
        case (mode)
            0:       return 32'(r);
            1:       return 32'd8;
            2:       return 32'd0;
            default: return 32'hFFFF_FFF8;
        endcase
    endfunction

    task automatic run_pass(input int mode, input bit gaps, input bit poke_start,
                            input string name);
        logic [W-1:0] got [NRES];
        int nwr, ndone, first_wr, last_wr, done_cyc, acc8;
        int min_gap, max_gap, order_err, next_addr, tail, guard;
        bit stuck, timed_out;
        nwr = 0; ndone = 0; first_wr = -1; last_wr = -1; done_cyc = -1; acc8 = -1;
        min_gap = 1 << 30; max_gap = 0; order_err = 0; next_addr = 0; tail = 0;
        stuck = 1'b0; timed_out = 1'b0;
        for (int i = 0; i < NRES; i++) got[i] = '0;

        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check_eq($sformatf("%s_busy_run", name), 32'(busy_o), 32'd1);

        fork
            begin
                for (int r = 0; r < NRES && !stuck; r++) begin
                    for (int k = 0; k < K && !stuck; k++) begin
                        while (gaps && $urandom_range(1, 0) == 0) begin
                            in_valid_i = 1'b0;
                            @(negedge clk);
                        end
                        in_valid_i = 1'b1;
                        in_a_i     = pair_a(mode, r, k);
                        in_b_i     = pair_b(mode, r, k);
                        start_i    = poke_start && (r == 20) && (k == 0);
                        guard = 0;
                        while (!in_ready_o && guard < 20) begin
                            @(negedge clk);
                            guard++;
                        end
                        if (!in_ready_o) begin
                            check_eq($sformatf("%s_ready_r%0d_k%0d", name, r, k),
                                     32'(in_ready_o), 32'd1);
                            stuck = 1'b1;
                        end
                        if (r == 0 && k == K - 1) acc8 = cyc;
                        @(negedge clk);
                        start_i = 1'b0;
                    end
                end
                // Extra pair after the final term must be refused while draining.
                in_valid_i = 1'b1;
                in_a_i     = 32'hDEAD_BEEF;
                in_b_i     = 32'h0000_0003;
                check_eq($sformatf("%s_drain_ready", name), 32'(in_ready_o), 32'd0);
                repeat (3) @(negedge clk);
                in_valid_i = 1'b0;
            end
            begin
                for (int n = 0; n < 4000 && tail < 10; n++) begin
                    @(negedge clk);
                    if (wr_en_o) begin
                        got[wr_address_o] = wr_data_o;
                        if (32'(wr_address_o) != 32'(next_addr)) order_err++;
                        next_addr++;
                        if (last_wr >= 0) begin
                            if (cyc - last_wr < min_gap) min_gap = cyc - last_wr;
                            if (cyc - last_wr > max_gap) max_gap = cyc - last_wr;
                        end
                        if (first_wr < 0) first_wr = cyc;
                        last_wr = cyc;
                        nwr++;
                    end
                    if (done_o) begin
                        ndone++;
                        done_cyc = cyc;
                    end
                    if (ndone > 0) tail++;
                end
                timed_out = (ndone == 0);
            end
        join

        check_eq($sformatf("%s_timeout", name), 32'(timed_out), 32'd0);
        check_eq($sformatf("%s_writes", name), nwr, NRES);
        check_eq($sformatf("%s_done_pulses", name), ndone, 1);
        check_eq($sformatf("%s_done_after_last_wr", name), done_cyc - last_wr, 1);
        check_eq($sformatf("%s_addr_order", name), order_err, 0);
        check_eq($sformatf("%s_busy_idle", name), 32'(busy_o), 32'd0);
        for (int r = 0; r < NRES; r++)
            check_eq($sformatf("%s_c%0d", name, r), got[r], exp_c(mode, r));
        if (!gaps) begin
            check_eq($sformatf("%s_first_wr_latency", name), first_wr - acc8, 3);
            check_eq($sformatf("%s_min_wr_gap", name), min_gap, 8);
            check_eq($sformatf("%s_max_wr_gap", name), max_gap, 8);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        check_eq($sformatf("%s_wr_en", name), 32'(wr_en_o), 32'd0);
        check_eq($sformatf("%s_wr_address", name), 32'(wr_address_o), 32'd0);
        check_eq($sformatf("%s_wr_data", name), wr_data_o, 32'd0);
        check_eq($sformatf("%s_in_ready", name), 32'(in_ready_o), 32'd0);
        check_eq($sformatf("%s_busy", name), 32'(busy_o), 32'd0);
        check_eq($sformatf("%s_done", name), 32'(done_o), 32'd0);
    endtask

    initial begin
        int nwr;
        rst_n      = 1'b0;
        start_i    = 1'b0;
        in_valid_i = 1'b0;
        in_a_i     = '0;
        in_b_i     = '0;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;

        run_pass(0, 1'b0, 1'b0, "ident");
        run_pass(1, 1'b0, 1'b0, "ones");
        run_pass(2, 1'b0, 1'b0, "wrap_zero");
        run_pass(3, 1'b0, 1'b0, "wrap_neg");
        run_pass(0, 1'b1, 1'b0, "ident_gaps");
        run_pass(1, 1'b0, 1'b1, "start_poke");

        // Abort during result 20: results 0..19 are out, result 20 is in the pipe.
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        nwr = 0;
        for (int i = 0; i < 164; i++) begin
            if (wr_en_o) nwr++;
            in_valid_i = 1'b1;
            in_a_i     = pair_a(0, i / 8, i % 8);
            in_b_i     = pair_b(0, i / 8, i % 8);
            if (i < 163) @(negedge clk);
        end
        check_eq("abort_writes_before", nwr, 20);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("abort");
        in_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nwr = 0;
        repeat (10) begin
            @(negedge clk);
            if (wr_en_o) nwr++;
        end
        check_eq("abort_writes_after", nwr, 0);
        check_eq("abort_busy_after", 32'(busy_o), 32'd0);

        run_pass(0, 1'b0, 1'b0, "post_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
